// File: rtl/toa_fine_encoder_pkg.sv
// Shared definitions for the TOA fine encoder.
//   GROUP_W_DEF / NGROUPS_DEF : default coarse-group geometry
//   calc_out_w()              : output code width for an N-bit delay line
//   ERR_CODE                  : all-ones error code (sliced to OUT_W by users)
//   win_sel_e                 : which window family the decoder selected
package toa_fine_encoder_pkg;

  localparam int GROUP_W_DEF = 8;
  localparam int NGROUPS_DEF = 8;

  localparam logic [31:0] ERR_CODE = '1;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_A    = 2'd1,
    SEL_B    = 2'd2
  } win_sel_e;

  function automatic int calc_out_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/toa_window_decode.sv
// Combinational fine decode of one GROUP_W-bit window.
//   i_win    : selected window bits, LSB first
//   i_level  : minimum accepted run length (0 acts as 1, 4..7 act as 3)
//   o_idx    : position of the lowest set bit
//   o_bubble : a set bit exists above the first zero that ends the run
//   o_short  : run length starting at o_idx is below the effective level
module toa_window_decode #(
  parameter int GROUP_W = 8
) (
  input  logic [GROUP_W-1:0]         i_win,
  input  logic [2:0]                 i_level,
  output logic [$clog2(GROUP_W)-1:0] o_idx,
  output logic                       o_bubble,
  output logic                       o_short
);

  localparam int IDX_W = $clog2(GROUP_W);
  localparam int RUN_W = $clog2(GROUP_W + 1);

  logic [IDX_W-1:0] w_idx;
  logic [RUN_W-1:0] w_run;
  logic [RUN_W-1:0] w_min;
  logic             w_in_run;
  logic             w_bubble;

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    w_idx = '0;
    for (int i = GROUP_W - 1; i >= 0; i--) begin
      if (i_win[i]) w_idx = IDX_W'(i);
    end
  end

  // Count the run from w_idx; any one after the run has ended is a bubble.
  always_comb begin
    w_run    = '0;
    w_in_run = 1'b1;
    w_bubble = 1'b0;
    for (int i = 0; i < GROUP_W; i++) begin
      if (i >= int'(w_idx)) begin
        if (!i_win[i])     w_in_run = 1'b0;
        else if (w_in_run) w_run    = w_run + 1'b1;
        else               w_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    if (i_level == 3'd0)     w_min = RUN_W'(1);
    else if (i_level > 3'd3) w_min = RUN_W'(3);
    else                     w_min = RUN_W'(i_level);
  end

  assign o_idx    = w_idx;
  assign o_bubble = w_bubble;
  assign o_short  = (w_run < w_min);

endmodule

// File: rtl/toa_fine_encoder_pipe.sv
// Three-stage thermometer-to-binary fine encoder for a tapped delay line.
//   clk, rstn     : clock, asynchronous active-low reset
//   valid_in      : encode_in / level valid this cycle
//   encode_in     : raw delay-line code, N = GROUP_W*NGROUPS-1 bits
//   level         : minimum accepted run length
//   cnt_clr       : synchronous clear of the event counters
//   valid_out     : binary_out and flags carry a new result
//   binary_out    : fine code (base+idx) mod N, or all ones on error
//   bubble_err    : {window-B bubble, window-A bubble}
//   code_err      : no usable window, or run shorter than level
//   bubble_cnt_a/b, err_cnt : saturating event counters
module toa_fine_encoder_pipe
  import toa_fine_encoder_pkg::*;
#(
  parameter int GROUP_W = GROUP_W_DEF,
  parameter int NGROUPS = NGROUPS_DEF,
  parameter int OUT_W   = calc_out_w(GROUP_W * NGROUPS - 1),
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         valid_in,
  input  logic [GROUP_W*NGROUPS-2:0]   encode_in,
  input  logic [2:0]                   level,
  input  logic                         cnt_clr,
  output logic                         valid_out,
  output logic [OUT_W-1:0]             binary_out,
  output logic [1:0]                   bubble_err,
  output logic                         code_err,
  output logic [CNT_W-1:0]             bubble_cnt_a,
  output logic [CNT_W-1:0]             bubble_cnt_b,
  output logic [CNT_W-1:0]             err_cnt
);

  localparam int             N     = GROUP_W * NGROUPS - 1;
  localparam int             IDX_W = $clog2(GROUP_W);
  localparam logic [OUT_W:0] N_EXT = (OUT_W + 1)'(N);

  // Window B[k] starts half a group up. Only the last one wraps; there the
  // padding bit Din[N] is pulled out to the MSB so the remaining taps stay
  // contiguous around the ring of N real taps.
  function automatic logic [GROUP_W-1:0] win_b(input logic [N:0] d, input int k);
    logic [GROUP_W-1:0] w;
    int                 p;
    w = '0;
    for (int j = 0; j < GROUP_W; j++) begin
      p = k * GROUP_W + GROUP_W / 2 + j;
      if (p < N)      w[j]     = d[p];
      else if (p > N) w[j - 1] = d[p - N - 1];
    end
    if (k * GROUP_W + GROUP_W / 2 + GROUP_W - 1 >= N) w[GROUP_W - 1] = d[N];
    return w;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [N:0]         w_din;
  logic [NGROUPS-1:0] w_ora;
  logic [NGROUPS-1:0] w_orb;

  logic               r_vld_p0;
  logic [N:0]         r_din_p0;
  logic [2:0]         r_lvl_p0;
  logic [NGROUPS-1:0] r_ora_p0;
  logic [NGROUPS-1:0] r_orb_p0;

  win_sel_e           w_sel;
  logic [GROUP_W-1:0] w_win;
  logic [OUT_W-1:0]   w_base;

  logic               r_vld_p1;
  win_sel_e           r_sel_p1;
  logic [GROUP_W-1:0] r_win_p1;
  logic [OUT_W-1:0]   r_base_p1;
  logic [2:0]         r_lvl_p1;

  logic [IDX_W-1:0]   w_idx;
  logic               w_dec_bub;
  logic               w_dec_short;
  logic               w_nowin;
  logic               w_bub;
  logic               w_cerr;
  logic [1:0]         w_bub_vec;
  logic [OUT_W:0]     w_sum;
  logic [OUT_W-1:0]   w_fine;
  logic [OUT_W-1:0]   w_bin;

  logic               r_vld_p2;
  logic [OUT_W-1:0]   r_bin_p2;
  logic [1:0]         r_bub_p2;
  logic               r_cerr_p2;
  logic [CNT_W-1:0]   r_cnt_a;
  logic [CNT_W-1:0]   r_cnt_b;
  logic [CNT_W-1:0]   r_cnt_e;

  assign w_din = {1'b0, encode_in};

  always_comb begin
    w_ora = '0;
    w_orb = '0;
    for (int k = 0; k < NGROUPS; k++) begin
      w_ora[k] = |w_din[k*GROUP_W +: GROUP_W];
      w_orb[k] = |win_b(w_din, k);
    end
  end

  // ---- Stage 1: padded code, level and group ORs ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_p0 <= 1'b0;
      r_din_p0 <= '0;
      r_lvl_p0 <= '0;
      r_ora_p0 <= '0;
      r_orb_p0 <= '0;
    end else begin
      r_vld_p0 <= valid_in;
      r_din_p0 <= w_din;
      r_lvl_p0 <= level;
      r_ora_p0 <= w_ora;
      r_orb_p0 <= w_orb;
    end
  end

  // A run that fits one A group is taken from A; one straddling two A groups
  // lands inside exactly one B window instead.
  always_comb begin
    w_sel  = SEL_NONE;
    w_win  = '0;
    w_base = '0;
    if ($onehot(r_ora_p0)) begin
      w_sel = SEL_A;
      for (int k = 0; k < NGROUPS; k++) begin
        if (r_ora_p0[k]) begin
          w_win  = r_din_p0[k*GROUP_W +: GROUP_W];
          w_base = OUT_W'(k * GROUP_W);
        end
      end
    end else if ($onehot(r_orb_p0)) begin
      w_sel = SEL_B;
      for (int k = 0; k < NGROUPS; k++) begin
        if (r_orb_p0[k]) begin
          w_win  = win_b(r_din_p0, k);
          w_base = OUT_W'(k * GROUP_W + GROUP_W / 2);
        end
      end
    end
  end

  // ---- Stage 2: selected window, its base and level ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_p1  <= 1'b0;
      r_sel_p1  <= SEL_NONE;
      r_win_p1  <= '0;
      r_base_p1 <= '0;
      r_lvl_p1  <= '0;
    end else begin
      r_vld_p1  <= r_vld_p0;
      r_sel_p1  <= w_sel;
      r_win_p1  <= w_win;
      r_base_p1 <= w_base;
      r_lvl_p1  <= r_lvl_p0;
    end
  end

  toa_window_decode #(
    .GROUP_W (GROUP_W)
  ) u_decode (
    .i_win    (r_win_p1),
    .i_level  (r_lvl_p1),
    .o_idx    (w_idx),
    .o_bubble (w_dec_bub),
    .o_short  (w_dec_short)
  );

  // A bubble takes priority over a short run so the two flags never coexist.
  assign w_nowin   = (r_sel_p1 == SEL_NONE);
  assign w_bub     = ~w_nowin & w_dec_bub;
  assign w_cerr    = w_nowin | (w_dec_short & ~w_dec_bub);
  assign w_bub_vec = {w_bub & (r_sel_p1 == SEL_B), w_bub & (r_sel_p1 == SEL_A)};
  assign w_sum     = {1'b0, r_base_p1} + (OUT_W + 1)'(w_idx);
  assign w_fine    = (w_sum >= N_EXT) ? OUT_W'(w_sum - N_EXT) : OUT_W'(w_sum);
  assign w_bin     = (w_bub | w_cerr) ? ERR_CODE[OUT_W-1:0] : w_fine;

  // ---- Stage 3: decoded result, held across valid gaps ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_p2  <= 1'b0;
      r_bin_p2  <= '0;
      r_bub_p2  <= '0;
      r_cerr_p2 <= 1'b0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_bin_p2  <= w_bin;
        r_bub_p2  <= w_bub_vec;
        r_cerr_p2 <= w_cerr;
      end
    end
  end

  // Counters advance on the same edge that loads stage 3, so a count is
  // already visible in the cycle its sample appears on valid_out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_cnt_e <= '0;
    end else if (cnt_clr) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_cnt_e <= '0;
    end else if (r_vld_p1) begin
      if (w_bub_vec[0]) r_cnt_a <= sat_inc(r_cnt_a);
      if (w_bub_vec[1]) r_cnt_b <= sat_inc(r_cnt_b);
      if (w_cerr)       r_cnt_e <= sat_inc(r_cnt_e);
    end
  end

  assign valid_out    = r_vld_p2;
  assign binary_out   = r_bin_p2;
  assign bubble_err   = r_bub_p2;
  assign code_err     = r_cerr_p2;
  assign bubble_cnt_a = r_cnt_a;
  assign bubble_cnt_b = r_cnt_b;
  assign err_cnt      = r_cnt_e;

endmodule

// File: doc/toa_fine_encoder_pipe.md
TOA_FINE_ENCODER_PIPE -- requirements
Module: toa_fine_encoder_pipe

Interface
REQ-001 The block SHALL have parameter GROUP_W, default 8, meaning bits per coarse group (even, >=4).
REQ-002 The block SHALL have parameter NGROUPS, default 8, meaning number of coarse groups; code width N = GROUP_W*NGROUPS-1 (default 63).
REQ-003 The block SHALL have parameter OUT_W, default 6, meaning output width = clog2(N+1).
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning error-counter width.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port rstn, input, 1, meaning the asynchronous active-low reset.
REQ-007 The block SHALL have port valid_in, input, 1, meaning encode_in and level are valid this cycle.
REQ-008 The block SHALL have port encode_in, input, N, meaning the raw delay-line code (a run of ones).
REQ-009 The block SHALL have port level, input, 3, meaning the minimum accepted run length.
REQ-010 The block SHALL have port cnt_clr, input, 1, meaning a synchronous clear of all counters.
REQ-011 The block SHALL have port valid_out, input... output, 1, meaning binary_out and the flags are valid.
REQ-012 The block SHALL have port binary_out, output, OUT_W, meaning the fine code or the error code (all ones).
REQ-013 The block SHALL have port bubble_err, output, 2, meaning {window-B bubble, window-A bubble}.
REQ-014 The block SHALL have port code_err, output, 1, meaning no valid window was found, or the run was too short.
REQ-015 The block SHALL have ports bubble_cnt_a, bubble_cnt_b and err_cnt, each output, CNT_W, meaning saturating event counters.

Function
REQ-016 Din SHALL be {1'b0, encode_in}, width N+1; bit N is the padding bit.
REQ-017 Window A[k] SHALL cover Din[k*G +: G]; window B[k] SHALL cover bits k*G+G/2 .. k*G+G/2+G-1, modulo N+1.
REQ-018 In the wrapping B window, the padding bit SHALL be moved to window MSB; all other bits keep LSB-first order.
REQ-019 Selection SHALL follow these rules:
- If the A-window OR vector is one-hot, use window A with base k*G.
- Else, if the B-window OR vector is one-hot, use window B with base k*G+G/2.
- Else, set code_err.
REQ-020 Fine decode:
- idx is the lowest set bit of the selected window.
- The ones from idx upward SHALL be contiguous; otherwise flag a bubble.
- A run length below max(level,1) SHALL set code_err; level values 4-7 SHALL be treated as 3.
REQ-021 binary_out SHALL be (base+idx) mod N when there is no error, otherwise all ones.
- A bubble SHALL force all ones.
- A bubble SHALL set bubble_err[0] if window A was used, else bubble_err[1].
- A bubble SHALL NOT set code_err.
REQ-022 The pipeline SHALL have 3 register stages:
- S1 registers Din, level and the group ORs.
- S2 registers the window select, the window bits and base.
- S3 registers the decode and output.
- Latency SHALL be exactly 3 cycles, valid_in to valid_out.
REQ-023 The pipeline SHALL accept one sample per cycle with no backpressure; valid gaps SHALL propagate unchanged.
REQ-024 When valid_out=0, binary_out and the flags SHALL hold their last values; counters SHALL NOT change.
REQ-025 Counters SHALL increment by 1 on each valid_out cycle with the matching flag, and saturate at 2^CNT_W-1.
REQ-026 When cnt_clr coincides with an increment, clear SHALL win (count=0); cnt_clr SHALL NOT affect the pipeline.

Reset
REQ-027 When rstn=0, all pipeline registers, valid flags, binary_out, bubble_err, code_err and counters SHALL go to 0 immediately.
REQ-028 Samples in flight at reset SHALL be discarded; valid_out SHALL first assert 3 cycles after the first valid_in following deassertion.

Structure
REQ-029 A shared package SHALL hold GROUP_W/NGROUPS defaults, the clog2-based OUT_W function and the all-ones error constant.
REQ-030 Fine decode SHALL be one sub-module, toa_window_decode: G-bit window plus level in, idx/bubble/short out, combinational.

Verification
REQ-031 Directed case: encode_in ones at bits 10..12, level=1 -> after 3 cycles binary_out=10, flags=0.
REQ-032 Directed case: ones at bits 6..9 (straddles A groups 0/1) -> window B0 used, binary_out=6.
REQ-033 Directed case: ones at bits 62,0,1 (wrap) -> binary_out=62; ones at bits 0..2 -> binary_out=0.
REQ-034 Directed case: ones at bits 10 and 12 only -> binary_out=63, bubble_err=2'b01, bubble_cnt_a+1.
REQ-035 Directed cases, each after 3 cycles:
- Input all zeros -> binary_out=63, code_err=1.
- Single one at bit 20 with level=3 -> binary_out=63, code_err=1.
- Same input with level=1 -> binary_out=20.
REQ-036 Counter case: force err_cnt to 16'hFFFE, then 3 error samples -> counter holds 16'hFFFF.
- cnt_clr asserted with an error sample -> counter reads 0.
- rstn pulsed mid-stream -> valid_out=0 until 3 cycles after the next valid_in.
